cs_resolve_adder: RTL

Multi-cycle carry-propagate adder that consumes the carry-save pair (Sum, Carry) produced by the 48-bit 4-2 compression stage of the MAF datapath and resolves it into a single binary result. It adds one SLICE-bit chunk per cycle, LSB slice first, with a registered inter-slice carry. Valid/ready handshakes are used on both sides. The block sits between the compressor tree and the normalisation/rounding stage.

---
 rtl/cs_resolve_adder_if.sv | 25 ++
 rtl/cs_resolve_adder.sv | 83 ++++++++
 2 files changed

// File: rtl/cs_resolve_adder_if.sv
// Handshake bundle between the compressor tree, the carry-save resolve adder
// and the normalisation stage.
interface cs_resolve_adder_if #(
  parameter int WIDTH = 48
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output in_valid, sum_in, carry_in, out_ready,
    input  in_ready, out_valid, result, cout, zero
  );

  modport slave (
    input  in_valid, sum_in, carry_in, out_ready,
    output in_ready, out_valid, result, cout, zero
  );
endinterface

// File: rtl/cs_resolve_adder.sv
// Multi-cycle carry-propagate adder: resolves a carry-save (sum, carry) pair
// one SLICE-bit chunk per cycle, LSB slice first, with a registered carry.
module cs_resolve_adder #(
  parameter int WIDTH = 48,
  parameter int SLICE = 16
) (
  input  logic              clk,
  input  logic              rst,
  cs_resolve_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] op_s;
  logic [WIDTH-1:0] op_c;
  logic             cr;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] next_result;
  logic             accept;

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // next_result is the full result with the current slice merged in, so the
  // zero flag on the final slice sees every bit of the new value.
  always_comb begin
    slice_sum   = {1'b0, op_s[k*SLICE +: SLICE]} + {1'b0, op_c[k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, cr};
    next_result = result_q;
    next_result[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      op_s     <= '0;
      op_c     <= '0;
      cr       <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_s  <= bus.sum_in;
            op_c  <= bus.carry_in;
            cr    <= 1'b0;
            k     <= '0;
            state <= ADD;
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
        ADD: begin
          result_q <= next_result;
          cr       <= slice_sum[SLICE];
          if (k == KW'(NSLICE - 1)) begin
            cout_q <= slice_sum[SLICE];
            zero_q <= (next_result == '0) & ~slice_sum[SLICE];
            state  <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
